// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a registered or FWFT read port.
module sync_fifo_prog #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int FWFT      = 0
) (
  input  logic                 clk_i,
  input  logic                 res_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  input  logic                 clr_err_i,
  input  logic [PTR_WIDTH:0]   af_thresh_i,
  input  logic [PTR_WIDTH:0]   ae_thresh_i,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]        count;
  logic                 wr_acc, rd_acc;

  // Handshake: a write transfers when wr_en_i && !full_o, a read (pop) when
  // rd_en_i && !empty_o; both use flags as they stand before the edge, so a
  // request is never accepted on the strength of the opposite side's transfer.
  assign wr_acc = wr_en_i && !full_o;
  assign rd_acc = rd_en_i && !empty_o;

  assign full_o         = (count == FULL_CNT);
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= af_thresh_i);
  assign almost_empty_o = (count <= ae_thresh_i);
  assign count_o        = count;

  // Explicit wrap keeps pointers inside 0..DEPTH-1 for non-power-of-two depths.
  always_comb begin
    wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_WIDTH'(1);
    rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr_nxt;
      if (rd_acc) rd_ptr <= rd_ptr_nxt;
      if (wr_acc && !rd_acc)      count <= count + CW'(1);
      else if (rd_acc && !wr_acc) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr] <= wdata_i;
  end

  // Setting an error flag takes priority over a simultaneous clear.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_en_i && full_o)  overflow_o <= 1'b1;
      else if (clr_err_i)     overflow_o <= 1'b0;
      if (rd_en_i && empty_o) underflow_o <= 1'b1;
      else if (clr_err_i)     underflow_o <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata_o = mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i)       rdata_q <= '0;
        else if (rd_acc) rdata_q <= mem[rd_ptr];
      end
      assign rdata_o = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: a DEPTH=16 registered-read FIFO and a DEPTH=5 FWFT FIFO.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // registered-read instance, DEPTH=16
  logic       res, wr_en, rd_en, clr_err;
  logic [7:0] wdata, rdata;
  logic [4:0] af_thresh, ae_thresh, count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  // FWFT instance, DEPTH=5
  logic       f_res, f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wdata, f_rdata;
  logic [3:0] f_af_thresh, f_ae_thresh, f_count;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
    .clk_i(clk), .res_i(res), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
    .rdata_o(rdata), .clr_err_i(clr_err), .af_thresh_i(af_thresh), .ae_thresh_i(ae_thresh),
    .count_o(count), .full_o(full), .empty_o(empty), .almost_full_o(almost_full),
    .almost_empty_o(almost_empty), .overflow_o(overflow), .underflow_o(underflow)
  );

  sync_fifo_prog #(.WIDTH(8), .DEPTH(5), .FWFT(1)) dut_f (
    .clk_i(clk), .res_i(f_res), .wr_en_i(f_wr_en), .wdata_i(f_wdata), .rd_en_i(f_rd_en),
    .rdata_o(f_rdata), .clr_err_i(f_clr_err), .af_thresh_i(f_af_thresh), .ae_thresh_i(f_ae_thresh),
    .count_o(f_count), .full_o(f_full), .empty_o(f_empty), .almost_full_o(f_almost_full),
    .almost_empty_o(f_almost_empty), .overflow_o(f_overflow), .underflow_o(f_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; clr_err = 0;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0;
  endtask

  task automatic test_reset();
    res = 1; f_res = 1; idle(); wdata = 0; f_wdata = 0;
    af_thresh = 5'd14; ae_thresh = 5'd2; f_af_thresh = 4'd4; f_ae_thresh = 4'd1;
    tick(); tick();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({empty, full} !== 2'b10) begin bad++; $display("FAIL reset_flags got=%b exp=10", {empty, full}); end
    total++; if ({almost_empty, almost_full} !== 2'b10) begin bad++; $display("FAIL reset_almost got=%b exp=10", {almost_empty, almost_full}); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
    total++; if ({f_count, f_empty} !== {4'd0, 1'b1}) begin bad++; $display("FAIL reset_f got=%0d/%b exp=0/1", f_count, f_empty); end
    @(negedge clk);
    res = 0; f_res = 0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1; wdata = 8'(i);
      tick();
      total++; if (count !== 5'(i)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
      total++; if (almost_full !== (i >= 14)) begin bad++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i >= 14)); end
      total++; if (full !== (i == 16)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i == 16)); end
    end
    total++; if (almost_empty !== 1'b0) begin bad++; $display("FAIL fill_ae got=%b exp=0", almost_empty); end
    idle();
  endtask

  task automatic test_overflow();
    wr_en = 1; wdata = 8'hAA;
    tick(); idle();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
    clr_err = 1;
    tick(); idle();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    clr_err = 1; wr_en = 1; wdata = 8'hAA;
    tick(); idle();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    clr_err = 1;
    tick(); idle();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr2 got=%b exp=0", overflow); end
  endtask

  task automatic test_drain_wrap();
    logic [7:0] e;
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1;
      tick();
      total++; if (rdata !== 8'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, rdata, 8'(i)); end
    end
    total++; if ({empty, count} !== {1'b1, 5'd0}) begin bad++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    rd_en = 1;
    tick(); idle();
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_set got=%b exp=1", underflow); end
    total++; if (rdata !== 8'h10) begin bad++; $display("FAIL udf_hold got=%h exp=10", rdata); end
    clr_err = 1;
    tick(); idle();
    // 20 words through a 16-deep buffer: 3 primed, 17 streamed, 3 drained
    for (int k = 0; k < 20; k++) begin
      wr_en = 1; wdata = 8'h40 + 8'(k); exp_q.push_back(wdata);
      rd_en = (k >= 3);
      if (k >= 3) e = exp_q.pop_front();
      tick();
      if (k >= 3) begin
        total++; if (rdata !== e) begin bad++; $display("FAIL wrap_data k=%0d got=%h exp=%h", k, rdata, e); end
      end
    end
    idle();
    while (exp_q.size() > 0) begin
      rd_en = 1; e = exp_q.pop_front();
      tick();
      total++; if (rdata !== e) begin bad++; $display("FAIL wrap_tail got=%h exp=%h", rdata, e); end
    end
    idle();
    total++; if ({empty, underflow} !== 2'b10) begin bad++; $display("FAIL wrap_end got=%b exp=10", {empty, underflow}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    for (int k = 0; k < 5; k++) begin
      wr_en = 1; wdata = 8'h60 + 8'(k); exp_q.push_back(wdata);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      wr_en = 1; rd_en = 1; wdata = 8'h70 + 8'(k); exp_q.push_back(wdata);
      e = exp_q.pop_front();
      tick();
      total++; if (count !== 5'd5) begin bad++; $display("FAIL b2b_count k=%0d got=%0d exp=5", k, count); end
      total++; if (rdata !== e) begin bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, rdata, e); end
    end
    idle();
    while (exp_q.size() > 0) begin
      rd_en = 1; e = exp_q.pop_front();
      tick();
      total++; if (rdata !== e) begin bad++; $display("FAIL b2b_tail got=%h exp=%h", rdata, e); end
    end
    idle();
    // both requests against an empty FIFO: only the write lands
    wr_en = 1; rd_en = 1; wdata = 8'h99;
    tick(); idle();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL empty_both_count got=%0d exp=1", count); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL empty_both_udf got=%b exp=1", underflow); end
    total++; if (rdata !== 8'h79) begin bad++; $display("FAIL empty_both_hold got=%h exp=79", rdata); end
    rd_en = 1; clr_err = 1;
    tick(); idle();
    total++; if (rdata !== 8'h99) begin bad++; $display("FAIL empty_both_data got=%h exp=99", rdata); end
    total++; if ({empty, underflow} !== 2'b10) begin bad++; $display("FAIL empty_both_end got=%b exp=10", {empty, underflow}); end
  endtask

  task automatic test_fwft();
    logic [7:0] e;
    f_wr_en = 1; f_wdata = 8'h3C;
    tick(); idle();
    total++; if (f_rdata !== 8'h3C) begin bad++; $display("FAIL fwft_first got=%h exp=3c", f_rdata); end
    total++; if ({f_empty, f_count} !== {1'b0, 4'd1}) begin bad++; $display("FAIL fwft_first_flags got=%b/%0d exp=0/1", f_empty, f_count); end
    f_rd_en = 1;
    tick(); idle();
    total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL fwft_pop got=%b exp=1", f_empty); end
    f_wr_en = 1; f_wdata = 8'h80; exp_q.push_back(f_wdata);
    tick();
    for (int k = 1; k <= 12; k++) begin
      e = exp_q.pop_front();
      total++; if (f_rdata !== e) begin bad++; $display("FAIL fwft_wrap k=%0d got=%h exp=%h", k, f_rdata, e); end
      f_wr_en = 1; f_rd_en = 1; f_wdata = 8'h80 + 8'(k); exp_q.push_back(f_wdata);
      tick();
      total++; if (f_count !== 4'd1) begin bad++; $display("FAIL fwft_count k=%0d got=%0d exp=1", k, f_count); end
    end
    idle();
    e = exp_q.pop_front();
    total++; if (f_rdata !== e) begin bad++; $display("FAIL fwft_last got=%h exp=%h", f_rdata, e); end
    f_rd_en = 1;
    tick(); idle();
    for (int k = 0; k < 5; k++) begin
      f_wr_en = 1; f_wdata = 8'hD0 + 8'(k);
      tick();
    end
    idle();
    total++; if ({f_full, f_almost_full, f_count} !== {1'b1, 1'b1, 4'd5}) begin bad++; $display("FAIL fwft_full got=%b%b/%0d exp=11/5", f_full, f_almost_full, f_count); end
    total++; if (f_rdata !== 8'hD0) begin bad++; $display("FAIL fwft_full_head got=%h exp=d0", f_rdata); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wdata = 8'hC0 + 8'(i);
      tick();
    end
    wdata = 8'hEE;
    tick(); idle();
    for (int i = 0; i < 9; i++) begin
      rd_en = 1;
      tick();
      total++; if (rdata !== 8'hC0 + 8'(i)) begin bad++; $display("FAIL ares_pre got=%h exp=%h", rdata, 8'hC0 + 8'(i)); end
    end
    idle();
    total++; if ({count, overflow} !== {5'd7, 1'b1}) begin bad++; $display("FAIL ares_setup got=%0d/%b exp=7/1", count, overflow); end
    #2 res = 1;
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL ares_count got=%0d exp=0", count); end
    total++; if ({empty, overflow} !== 2'b10) begin bad++; $display("FAIL ares_flags got=%b exp=10", {empty, overflow}); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL ares_rdata got=%h exp=00", rdata); end
    tick();
    res = 0;
    wr_en = 1; wdata = 8'h5A;
    tick();
    wdata = 8'h5B;
    tick(); idle();
    rd_en = 1;
    tick(); idle();
    total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL ares_first got=%h exp=5a", rdata); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL ares_occ got=%0d exp=1", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_wrap();
    test_back_to_back();
    test_fwft();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO in the buffering library. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky error flags with an explicit clear, and a selectable read mode (registered or first-word-fall-through). It sits between producer and consumer logic in the same clock domain, where no pointer synchronisation is needed.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 16, number of entries; any value >= 2 (power of two not required)
- PTR_WIDTH, $clog2(DEPTH), pointer width; count and threshold width is PTR_WIDTH+1
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- clk_i  in  1  single clock; all state changes on the rising edge
- res_i  in  1  reset, asynchronous, active-high
- wr_en_i  in  1  write request
- wdata_i  in  WIDTH  write data
- rd_en_i  in  1  read (pop) request
- rdata_o  out  WIDTH  read data
- clr_err_i  in  1  clears overflow_o and underflow_o
- af_thresh_i  in  PTR_WIDTH+1  almost-full threshold (quasi-static)
- ae_thresh_i  in  PTR_WIDTH+1  almost-empty threshold (quasi-static)
- count_o  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- almost_full_o  out  1  count_o >= af_thresh_i
- almost_empty_o  out  1  count_o <= ae_thresh_i
- overflow_o  out  1  sticky: write attempted while full
- underflow_o  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x WIDTH array. Write pointer and read pointer are PTR_WIDTH wide, plus a count register.
- Write accepted (wr_acc) = wr_en_i && !full_o. Store wdata_i at wr_ptr and advance wr_ptr.
- Read accepted (rd_acc) = rd_en_i && !empty_o. Advance rd_ptr.
- full_o and empty_o are evaluated before the edge. A write while full is rejected even if a read occurs in the same cycle. A read while empty is rejected even if a write occurs in the same cycle.
- Pointer wrap: when a pointer equals DEPTH-1 and advances, it goes to 0. Pointers never take values >= DEPTH.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur. Count never leaves the range 0..DEPTH.
- full_o, empty_o, almost_full_o and almost_empty_o are combinational decodes of the count register and the threshold inputs.
- Errors: wr_en_i && full_o sets overflow_o. rd_en_i && empty_o sets underflow_o. clr_err_i clears both. If a set and clr_err_i occur in the same cycle, the set wins.
- Rejected operations do not modify pointers, count, memory or rdata_o.
- Read modes:
  - FWFT=0: on rd_acc, rdata_o is loaded from mem[rd_ptr] and holds until the next rd_acc.
  - FWFT=1: rdata_o = mem[rd_ptr] combinationally and is valid whenever !empty_o. rd_acc pops the head. rdata_o is don't-care while empty.
- Reset (res_i=1, asynchronous): wr_ptr=0, rd_ptr=0, count_o=0, rdata_o=0 (FWFT=0), overflow_o=0, underflow_o=0. Resulting flags: empty_o=1, full_o=0. almost_empty_o and almost_full_o follow the thresholds. Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. Occupancy restarts at 0 at the first edge after release.

## Timing
- Write-to-visible latency: count_o and the flags update on the same edge that accepts the write. Data written at edge N is readable at edge N+1.
- FWFT=1: a word written into an empty FIFO at edge N appears on rdata_o after edge N with empty_o=0. This gives a first-word latency of 1 cycle.
- FWFT=0: rdata_o is valid after the edge that accepts rd_en_i, i.e. 1-cycle read latency.
- Simultaneous wr_acc and rd_acc: both happen on one edge. Count and flags are unchanged. Throughput is one word per cycle in each direction.
- Threshold changes take effect combinationally on the almost flags. Changing thresholds while the FIFO is active is legal but produces transient flag values.
- Sticky error flags assert on the edge after the offending request and stay asserted until cleared or reset.

## Test plan
- Reset then fill: DEPTH=16, write 0x01..0x10 on consecutive cycles. Required: count_o steps 1..16; full_o=1 after the 16th edge; almost_full_o=1 from count 14 with af_thresh_i=14.
- Overflow and clear: with the FIFO full, write 0xAA. Required: overflow_o=1, count_o stays 16, 0xAA never read back. Pulse clr_err_i: overflow_o=0. Pulse clr_err_i together with another full write: overflow_o stays 1.
- Drain and wrap (FWFT=0): read 16 words. Required: 0x01..0x10 in order, 1 cycle after each rd_en_i; empty_o=1 at the end. Then a 17th read gives underflow_o=1 and rdata_o holds 0x10. Then write/read 20 more words: the pointers wrap and the data stays in order.
- Simultaneous read/write: at count 5, assert wr_en_i and rd_en_i for 10 cycles. Required: count_o stays 5 and output order is preserved. At count 0, assert both: only the write is accepted (count 1) and underflow_o=1.
- FWFT=1, DEPTH=5 (non-power-of-two): write 0x3C into an empty FIFO. Required: rdata_o=0x3C and empty_o=0 one cycle later, before any rd_en_i. Also: 12 write/read pairs wrap at index 4 -> 0 with the data intact.
- Asynchronous reset mid-stream: assert res_i between clock edges at count 7 with overflow_o=1. Required: immediately count_o=0, empty_o=1, overflow_o=0, rdata_o=0. After release, the first written word is the first read.
